change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//   Downstream of the drink-vending FSM. Queues change requests (charge_vld/charge_coin)
//   and pays each out coin by coin through two hoppers (1.0 and 0.5 units).
//   Each coin is confirmed by its hopper's exit sensor, and a jam is detected by timeout.
//   Decouples vending-FSM timing from slow electromechanical payout.
// PARAMETERS
//   FIFO_DEPTH   4    request queue entries (power of 2, >=2)
//   PULSE_CYC    8    hopper enable pulse length per coin, cycles
//   GAP_CYC      4    idle cycles between coins after a detect
//   TIMEOUT_CYC  64   cycles from FEED entry without a matching detect -> jam
// PORTS
//   clk          in   1  clock
//   rst_n        in   1  reset, asynchronous, active-low
//   charge_vld   in   1  1-cycle strobe: charge_coin valid
//   charge_coin  in   3  change owed, units of 0.5 (0..7)
//   det_1        in   1  1-cycle pulse: 1.0 coin passed exit sensor (synchronous)
//   det_05       in   1  1-cycle pulse: 0.5 coin passed exit sensor (synchronous)
//   err_clr      in   1  clears jam state
//   hop1_en      out  1  drive 1.0 hopper motor
//   hop05_en     out  1  drive 0.5 hopper motor
//   busy         out  1  state!=IDLE or queue non-empty
//   chg_done     out  1  1-cycle pulse: current request fully paid
//   jam_err      out  1  level: hopper jam, payout halted
//   req_full     out  1  queue full (registered count==FIFO_DEPTH)
//   req_drop     out  1  1-cycle pulse: request discarded because queue full
// BEHAVIOUR
//   Reset: all outputs 0, queue empty, state IDLE, all counters 0. The reset is asynchronous and takes effect mid-payout.
//   Push: at edge T, charge_vld=1 and charge_coin!=0 -> push if req_full=0. If req_full=1 -> discard and assert req_drop at T+1.
//     charge_coin==0 -> ignored, no drop. Full is the pre-edge value; a pop in the same cycle does not make room.
//   FSM states: IDLE, LOAD, FEED, WAIT, GAP, DONE, ERR. Outputs are decoded from registered state/counters.
//   IDLE: queue non-empty -> LOAD. LOAD pops the head entry: n1 = coin>>1 (2 bits), n05 = coin[0].
//   LOAD -> FEED. The selected hopper is 1.0 when n1!=0, otherwise 0.5.
//   FEED: hop1_en or hop05_en (only one, never both) high for PULSE_CYC cycles, then WAIT.
//   Matching detect in FEED or WAIT: decrement n1 or n05, drop the enable immediately -> GAP.
//     A detect from the other hopper, or any detect outside FEED/WAIT, is ignored.
//   GAP: GAP_CYC cycles with no enable. Then FEED if n1+n05!=0, else DONE.
//   DONE: chg_done=1 for exactly one cycle -> IDLE.
//   Timeout counter: cleared on each FEED entry, counts in FEED and WAIT.
//     Reaching TIMEOUT_CYC without a matching detect -> ERR.
//   ERR: jam_err=1, both enables 0. The in-flight request is abandoned (its remainder is lost, no chg_done).
//     The queue is retained and pushes continue. err_clr=1 -> IDLE with jam_err=0 next cycle.
//   Latency: push at edge T while idle -> LOAD at T+1, first enable high from T+2.
//   Counters are sized to $clog2(max+1). There is no wrap: all counters saturate or clear at their terminal count.
// TESTING
//   1. coin=3, det_1 at pulse cycle 5, det_05 at WAIT cycle 2 -> hop1_en 5 cyc, 4-cyc gap, hop05_en pulse, then 4-cyc gap, chg_done x1.
//   2. charge_vld with coin=0 -> no push, busy=0, req_drop=0.
//   3. Six consecutive strobes while idle, no dets: #1 popped, #2-5 fill queue (req_full=1), #6 -> req_drop single pulse.
//   4. coin=2, no detects -> enable 8 cycles, jam_err=1 at 64 cycles after FEED entry. err_clr -> next queued request starts.
//   5. rst_n low during WAIT -> enables, busy, jam_err at 0 immediately. After release the queue is empty.
//   6. coin=1 (0.5 hopper active), det_1 pulses only -> ignored, timeout -> jam_err=1.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Signal bundle between the vending FSM / hopper hardware (master) and the change dispenser (slave).
interface change_dispenser_if;
  logic       charge_vld;
  logic [2:0] charge_coin;
  logic       det_1;
  logic       det_05;
  logic       err_clr;
  logic       hop1_en;
  logic       hop05_en;
  logic       busy;
  logic       chg_done;
  logic       jam_err;
  logic       req_full;
  logic       req_drop;

  modport master (
    output charge_vld, charge_coin, det_1, det_05, err_clr,
    input  hop1_en, hop05_en, busy, chg_done, jam_err, req_full, req_drop
  );

  modport slave (
    input  charge_vld, charge_coin, det_1, det_05, err_clr,
    output hop1_en, hop05_en, busy, chg_done, jam_err, req_full, req_drop
  );
endinterface

// File: rtl/change_dispenser.sv
// Queues change requests and pays each out coin by coin through the 1.0 and 0.5 hoppers,
// confirming every coin by its exit sensor and flagging a jam on timeout.
module change_dispenser #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned PULSE_CYC   = 8,
  parameter int unsigned GAP_CYC     = 4,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  change_dispenser_if.slave  bus
);

  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PCW = $clog2(PULSE_CYC + 1);
  localparam int unsigned GCW = $clog2(GAP_CYC + 1);
  localparam int unsigned TCW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [PW-1:0]  PTR_LAST   = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0]  CNT_FULL   = CW'(FIFO_DEPTH);
  localparam logic [PCW-1:0] PULSE_LAST = PCW'(PULSE_CYC - 1);
  localparam logic [GCW-1:0] GAP_LAST   = GCW'(GAP_CYC - 1);
  localparam logic [TCW-1:0] TMO_LAST   = TCW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FEED, S_WAIT, S_GAP, S_DONE, S_ERR
  } state_e;

  state_e         state_q, state_d;
  logic [2:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [PCW-1:0] pulse_q, pulse_d;
  logic [GCW-1:0] gap_q, gap_d;
  logic [TCW-1:0] tmo_q, tmo_d;
  logic [1:0]     n1_q, n1_d;
  logic           n05_q, n05_d;
  logic           drop_q;

  logic req, full, push, pop, sel1, match;

  // Full is the registered count, so a pop in the same cycle never makes room for a push.
  assign full = (cnt_q == CNT_FULL);
  assign req  = bus.charge_vld && (bus.charge_coin != 3'd0);
  assign push = req && !full;
  assign pop  = (state_q == S_LOAD);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.charge_coin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
      cnt_q  <= cnt_d;
      drop_q <= req && full;
    end
  end

  assign sel1  = (n1_q != 2'd0);
  assign match = sel1 ? bus.det_1 : bus.det_05;

  always_comb begin
    state_d = state_q;
    pulse_d = pulse_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    n1_d    = n1_q;
    n05_d   = n05_q;
    unique case (state_q)
      S_IDLE: if (cnt_q != '0) state_d = S_LOAD;
      S_LOAD: begin
        n1_d    = mem_q[rd_ptr_q][2:1];
        n05_d   = mem_q[rd_ptr_q][0];
        pulse_d = '0;
        tmo_d   = '0;
        state_d = S_FEED;
      end
      S_FEED, S_WAIT: begin
        // A matching detect wins over both the pulse end and the timeout.
        if (match) begin
          if (sel1) n1_d = n1_q - 2'd1;
          else      n05_d = 1'b0;
          gap_d   = '0;
          state_d = S_GAP;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TCW'(1);
          if (state_q == S_FEED) begin
            if (pulse_q == PULSE_LAST) state_d = S_WAIT;
            else                       pulse_d = pulse_q + PCW'(1);
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          pulse_d = '0;
          tmo_d   = '0;
          state_d = ((n1_q != 2'd0) || n05_q) ? S_FEED : S_DONE;
        end else begin
          gap_d = gap_q + GCW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   if (bus.err_clr) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pulse_q <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
      n1_q    <= '0;
      n05_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      n1_q    <= n1_d;
      n05_q   <= n05_d;
    end
  end

  assign bus.hop1_en  = (state_q == S_FEED) && sel1;
  assign bus.hop05_en = (state_q == S_FEED) && !sel1;
  assign bus.busy     = (state_q != S_IDLE) || (cnt_q != '0);
  assign bus.chg_done = (state_q == S_DONE);
  assign bus.jam_err  = (state_q == S_ERR);
  assign bus.req_full = full;
  assign bus.req_drop = drop_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench: each request is expanded into an expected per-cycle timeline from the payout rules.
module tb_change_dispenser;
  localparam int PULSE = 8;
  localparam int GAP   = 4;
  localparam int TMO   = 64;

  logic clk = 1'b0;
  logic rst_n;

  change_dispenser_if bus ();

  change_dispenser #(
    .FIFO_DEPTH(4), .PULSE_CYC(PULSE), .GAP_CYC(GAP), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic       vld;
    logic [2:0] coin;
    logic       clr;
    logic       d1;
    logic       d05;
    logic       h1;
    logic       h05;
    logic       done;
    logic       busy;
    logic       jam;
  } cyc_t;

  cyc_t sched[$];

  function automatic logic rb();
    return ($urandom_range(0, 3) == 0);
  endfunction

  function automatic void add(input logic vld, input logic [2:0] coin, input logic clr,
                              input logic d1, input logic d05, input logic h1, input logic h05,
                              input logic done, input logic busy, input logic jam);
    cyc_t e;
    e.vld = vld; e.coin = coin; e.clr = clr; e.d1 = d1; e.d05 = d05;
    e.h1 = h1; e.h05 = h05; e.done = done; e.busy = busy; e.jam = jam;
    sched.push_back(e);
  endfunction

  function automatic void idle(input int n);
    for (int i = 0; i < n; i++)
      add(1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // Timeline of one request from the cycle after the previous one ends (IDLE, LOAD, then coins).
  // jam_at selects the coin whose detect never comes; d0/d1 force the detect cycle of coins 0/1.
  task automatic build_req(input logic [2:0] coin, input int jam_at, input int d0, input int d1);
    int   n1, n, d, nerr;
    logic one;
    n1 = int'(coin[2:1]);
    n  = n1 + int'(coin[0]);
    add(1'b0, 3'd0, 1'b0, rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 3'd0, 1'b0, rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      one = (i < n1);
      if (i == jam_at) begin
        for (int c = 1; c <= TMO; c++)
          add(1'b0, 3'd0, 1'b0, one ? 1'b0 : rb(), one ? rb() : 1'b0,
              one && (c <= PULSE), !one && (c <= PULSE), 1'b0, 1'b1, 1'b0);
        nerr = $urandom_range(1, 3);
        for (int r = 1; r <= nerr; r++)
          add(1'b0, 3'd0, (r == nerr), rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        return;
      end
      if (i == 0 && d0 > 0)      d = d0;
      else if (i == 1 && d1 > 0) d = d1;
      else                       d = $urandom_range(1, 24);
      for (int c = 1; c <= d; c++)
        add(1'b0, 3'd0, 1'b0, one ? (c == d) : rb(), one ? rb() : (c == d),
            one && (c <= PULSE), !one && (c <= PULSE), 1'b0, 1'b1, 1'b0);
      for (int g = 1; g <= GAP; g++)
        add(1'b0, 3'd0, 1'b0, rb(), rb(), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    add(1'b0, 3'd0, 1'b0, rb(), rb(), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic push_req(input logic [2:0] coin);
    add(1'b1, coin, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_sched();
    cyc_t e;
    while (sched.size() > 0) begin
      e = sched.pop_front();
      @(negedge clk);
      check("hop1_en",  bus.hop1_en,  e.h1);
      check("hop05_en", bus.hop05_en, e.h05);
      check("chg_done", bus.chg_done, e.done);
      check("busy",     bus.busy,     e.busy);
      check("jam_err",  bus.jam_err,  e.jam);
      check("req_drop", bus.req_drop, 1'b0);
      bus.charge_vld  = e.vld;
      bus.charge_coin = e.coin;
      bus.err_clr     = e.clr;
      bus.det_1       = e.d1;
      bus.det_05      = e.d05;
    end
  endtask

  logic [2:0] coins [6];
  logic [2:0] c;
  logic       sel_one, en;
  int         ncoin, jam_at, j;

  initial begin
    bus.charge_vld = 1'b0; bus.charge_coin = 3'd0; bus.det_1 = 1'b0;
    bus.det_05 = 1'b0; bus.err_clr = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hop1",  bus.hop1_en,  1'b0);
    check("rst_hop05", bus.hop05_en, 1'b0);
    check("rst_busy",  bus.busy,     1'b0);
    check("rst_done",  bus.chg_done, 1'b0);
    check("rst_jam",   bus.jam_err,  1'b0);
    check("rst_full",  bus.req_full, 1'b0);
    check("rst_drop",  bus.req_drop, 1'b0);
    rst_n = 1'b1;

    // Zero-coin strobe is ignored
    @(negedge clk); bus.charge_vld = 1'b1; bus.charge_coin = 3'd0;
    @(negedge clk); bus.charge_vld = 1'b0;
    check("zero_busy", bus.busy, 1'b0);
    check("zero_drop", bus.req_drop, 1'b0);
    @(negedge clk);
    check("zero_busy2", bus.busy, 1'b0);

    // coin=3: det_1 at pulse cycle 5, det_05 at WAIT cycle 2
    push_req(3'd3); build_req(3'd3, -1, 5, PULSE + 2); idle(3); run_sched();

    // coin=1 with only det_1 noise: times out on the 0.5 hopper
    push_req(3'd1); build_req(3'd1, 0, 0, 0); idle(2); run_sched();

    for (int it = 0; it < 14; it++) begin
      c      = 3'($urandom_range(1, 7));
      ncoin  = int'(c[2:1]) + int'(c[0]);
      jam_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, ncoin - 1)) : -1;
      push_req(c); build_req(c, jam_at, 0, 0); idle($urandom_range(1, 3)); run_sched();
    end

    // Six strobes: first pops, four fill, sixth drops; first request then jams
    for (int k = 0; k < 6; k++) coins[k] = 3'($urandom_range(1, 7));
    sel_one = (coins[0] >= 3'd2);
    for (int k = 1; k <= 70; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        j  = k - 1;
        en = (j >= 3) && (j <= 2 + PULSE);
        check("fill_hop1",  bus.hop1_en,  en && sel_one);
        check("fill_hop05", bus.hop05_en, en && !sel_one);
        check("fill_jam",   bus.jam_err,  j >= 3 + TMO);
        check("fill_busy",  bus.busy,     1'b1);
        check("fill_full",  bus.req_full, j >= 5);
        if (j <= 8) check("fill_drop", bus.req_drop, j == 6);
      end
      bus.charge_vld  = (k <= 6);
      bus.charge_coin = (k <= 6) ? coins[k-1] : 3'd0;
    end
    add(1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 4; k++) build_req(coins[k], -1, 0, 0);
    idle(2);
    run_sched();

    // Asynchronous reset during WAIT discards the queued request
    c = 3'($urandom_range(1, 7));
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      bus.charge_vld  = (k <= 2);
      bus.charge_coin = (k <= 2) ? c : 3'd0;
    end
    check("wait_hop1", bus.hop1_en,  1'b0);
    check("wait_busy", bus.busy,     1'b1);
    rst_n = 1'b0;
    #1;
    check("arst_hop1",  bus.hop1_en,  1'b0);
    check("arst_hop05", bus.hop05_en, 1'b0);
    check("arst_busy",  bus.busy,     1'b0);
    check("arst_jam",   bus.jam_err,  1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_busy", bus.busy,     1'b0);
      check("post_hop",  bus.hop1_en | bus.hop05_en, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
